// File: rtl/vcu9p_mmcm_drp_ctrl.sv
// -----------------------------------------------------------------------------
// vcu9p_mmcm_drp_ctrl
// Runtime reconfiguration sequencer for an MMCME4. On a request it holds the
// MMCM in reset, read-modify-writes N_WR DRP registers taken from a constant
// configuration table, releases reset and waits (bounded) for lock.
//
// Ports
//   i_clk        controller / DRP clock (free-running MMCM input clock)
//   i_rst        synchronous active-high reset
//   i_req        one-cycle reconfiguration request
//   i_cfg_sel    configuration index, sampled with i_req
//   o_busy       sequence in progress
//   o_done       one-cycle pulse: sequence finished and MMCM locked
//   o_err        sticky error (bad index, DRDY timeout, lock timeout)
//   o_daddr/o_den/o_dwe/o_di, i_do/i_drdy   MMCM DRP port
//   o_mmcm_rst   MMCM RST
//   i_locked     MMCM LOCKED (asynchronous)
//   o_locked     i_locked after a 2-flop synchronizer
// -----------------------------------------------------------------------------
module vcu9p_mmcm_drp_ctrl #(
  parameter int unsigned N_CFG        = 2,
  parameter int unsigned N_WR         = 4,
  parameter logic [N_CFG*N_WR*39-1:0] CFG_TABLE = '0,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 65536
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [2:0]  i_cfg_sel,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [6:0]  o_daddr,
  output logic        o_den,
  output logic        o_dwe,
  output logic [15:0] o_di,
  input  logic [15:0] i_do,
  input  logic        i_drdy,
  output logic        o_mmcm_rst,
  input  logic        i_locked,
  output logic        o_locked
);

  localparam int unsigned ENT_W   = 39;
  localparam int unsigned N_ENT   = N_CFG * N_WR;
  localparam int unsigned FI_W    = $clog2(N_ENT + 1);
  localparam int unsigned IDX_W   = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_WR - 1);
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       N_CFG_V   = 4'(N_CFG);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RST_ON    = 4'd1,
    ST_RD        = 4'd2,
    ST_RD_WAIT   = 4'd3,
    ST_WR        = 4'd4,
    ST_WR_WAIT   = 4'd5,
    ST_RST_OFF   = 4'd6,
    ST_LOCK_WAIT = 4'd7,
    ST_ERR       = 4'd8
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [2:0]       cfg_r;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             accept_s, bad_req_s;
  logic             lock_meta_r;

  logic [FI_W-1:0]  flat_s;
  logic [ENT_W-1:0] entry_s;
  logic [6:0]       ent_addr_s;
  logic [15:0]      ent_mask_s, ent_data_s;

  logic             busy_nxt_s, done_nxt_s, err_nxt_s;
  logic             den_nxt_s, dwe_nxt_s, mmcm_rst_nxt_s;
  logic [6:0]       daddr_nxt_s;
  logic [15:0]      di_nxt_s;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic, including entry index and shared timeout counter.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    bad_req_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A request coinciding with the done pulse is dropped.
        if (i_req && !o_done) begin
          if ({1'b0, i_cfg_sel} < N_CFG_V) begin
            accept_s    = 1'b1;
            idx_nxt_s   = '0;
            state_nxt_s = ST_RST_ON;
          end else begin
            bad_req_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RST_ON: state_nxt_s = ST_RD;
      ST_RD: begin
        cnt_nxt_s   = '0;
        state_nxt_s = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (i_drdy) begin
          state_nxt_s = ST_WR;
        end else if (cnt_r == DRDY_LAST) begin
          state_nxt_s = ST_ERR;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_WR: begin
        cnt_nxt_s   = '0;
        state_nxt_s = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (i_drdy) begin
          if (idx_r == IDX_LAST) begin
            state_nxt_s = ST_RST_OFF;
          end else begin
            idx_nxt_s   = idx_r + IDX_W'(1);
            state_nxt_s = ST_RD;
          end
        end else if (cnt_r == DRDY_LAST) begin
          state_nxt_s = ST_ERR;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RST_OFF: begin
        cnt_nxt_s   = '0;
        state_nxt_s = ST_LOCK_WAIT;
      end
      ST_LOCK_WAIT: begin
        // o_locked is forced low while the MMCM sits in reset, so a high
        // value here is a genuine post-reconfiguration lock.
        if (o_locked) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == LOCK_LAST) begin
          state_nxt_s = ST_ERR;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_ERR:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Table lookup for the entry the next DRP access will use.
  always_comb begin
    flat_s  = FI_W'(cfg_r) * FI_W'(N_WR) + FI_W'(idx_nxt_s);
    entry_s = '0;
    for (int unsigned k = 0; k < N_ENT; k++) begin
      if (flat_s == FI_W'(k)) begin
        entry_s = CFG_TABLE[k*ENT_W +: ENT_W];
      end else begin
        entry_s = entry_s;
      end
    end
    ent_addr_s = entry_s[38:32];
    ent_mask_s = entry_s[31:16];
    ent_data_s = entry_s[15:0];
  end

  // Output decode: next values of the registered outputs.
  always_comb begin
    busy_nxt_s     = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_ERR);
    mmcm_rst_nxt_s = (state_nxt_s == ST_RST_ON) || (state_nxt_s == ST_RD) ||
                     (state_nxt_s == ST_RD_WAIT) || (state_nxt_s == ST_WR) ||
                     (state_nxt_s == ST_WR_WAIT);
    den_nxt_s      = (state_nxt_s == ST_RD) || (state_nxt_s == ST_WR);
    dwe_nxt_s      = (state_nxt_s == ST_WR);
    done_nxt_s     = (state_r == ST_LOCK_WAIT) && (state_nxt_s == ST_IDLE);
    if (den_nxt_s) begin
      daddr_nxt_s = ent_addr_s;
    end else begin
      daddr_nxt_s = o_daddr;
    end
    // Entering WR happens exactly on the RD_WAIT cycle where i_do is valid.
    if (state_nxt_s == ST_WR) begin
      di_nxt_s = (i_do & ent_mask_s) | (ent_data_s & ~ent_mask_s);
    end else begin
      di_nxt_s = o_di;
    end
    if (accept_s) begin
      err_nxt_s = 1'b0;
    end else if (bad_req_s || (state_nxt_s == ST_ERR)) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = o_err;
    end
  end

  // Datapath registers: selected configuration, entry index, timeout counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cfg_r <= 3'd0;
      idx_r <= '0;
      cnt_r <= '0;
    end else begin
      cfg_r <= accept_s ? i_cfg_sel : cfg_r;
      idx_r <= idx_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_daddr    <= 7'd0;
      o_den      <= 1'b0;
      o_dwe      <= 1'b0;
      o_di       <= 16'd0;
      o_mmcm_rst <= 1'b0;
    end else begin
      o_busy     <= busy_nxt_s;
      o_done     <= done_nxt_s;
      o_err      <= err_nxt_s;
      o_daddr    <= daddr_nxt_s;
      o_den      <= den_nxt_s;
      o_dwe      <= dwe_nxt_s;
      o_di       <= di_nxt_s;
      o_mmcm_rst <= mmcm_rst_nxt_s;
    end
  end

  // Two-flop synchronizer for the asynchronous LOCKED input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_meta_r <= 1'b0;
      o_locked    <= 1'b0;
    end else begin
      lock_meta_r <= i_locked;
      o_locked    <= lock_meta_r;
    end
  end

endmodule

// File: doc/vcu9p_mmcm_drp_ctrl.md
# vcu9p_mmcm_drp_ctrl

Dynamic-reconfiguration sequencer for the VCU9P MMCME4 clock generator. On request it holds the MMCM in reset, applies a selected set of read-modify-write updates through the MMCM DRP port, releases reset, and waits for lock with a timeout. It runs in the free-running input-clock domain that also clocks the DRP. It lets software switch the SoC clock frequency at runtime without a bitstream change.

## Interface
- N_CFG, 2: number of selectable configurations (1..8).
- N_WR, 4: DRP register updates per configuration (1..16).
- CFG_TABLE, all zeros: packed N_CFG*N_WR entries of 39 bits, {addr[6:0], mask[15:0], data[15:0]}. Entry k of config c is at bits [(c*N_WR+k)*39 +: 39].
- DRDY_TIMEOUT, 64: cycles to wait for i_drdy before flagging an error.
- LOCK_TIMEOUT, 65536: cycles to wait for lock after reset release.

- i_clk  in  1  DRP/controller clock (MMCM input clock, 125 MHz).
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  1  one-cycle reconfiguration request.
- i_cfg_sel  in  3  configuration index, sampled when i_req=1.
- o_busy  out  1  high from request acceptance until DONE or ERR.
- o_done  out  1  one-cycle pulse: reconfiguration succeeded and MMCM locked.
- o_err  out  1  sticky error flag; cleared by the next accepted request or by i_rst.
- o_daddr  out  7  DRP address.
- o_den  out  1  DRP enable, one-cycle pulse.
- o_dwe  out  1  DRP write enable, valid with o_den.
- o_di  out  16  DRP write data.
- i_do  in  16  DRP read data, valid with i_drdy.
- i_drdy  in  1  DRP ready.
- o_mmcm_rst  out  1  MMCM RST.
- i_locked  in  1  MMCM LOCKED, asynchronous.
- o_locked  out  1  i_locked after a 2-flop synchronizer.

## Operation
- States: IDLE, RST_ON, RD, RD_WAIT, WR, WR_WAIT, RST_OFF, LOCK_WAIT, ERR.
- IDLE: i_req=1 with i_cfg_sel<N_CFG latches the selection, clears the entry index and o_err, and moves to RST_ON. i_req=1 with i_cfg_sel>=N_CFG sets o_err and stays in IDLE. i_req outside IDLE is ignored.
- RST_ON: assert o_mmcm_rst, then go to RD.
- RD: pulse o_den with o_dwe=0 and o_daddr=entry.addr, then go to RD_WAIT.
- RD_WAIT: on i_drdy, capture i_do and go to WR.
- WR: pulse o_den with o_dwe=1, the same address, and o_di=(captured & mask) | (data & ~mask). Then go to WR_WAIT.
- WR_WAIT: on i_drdy, if index=N_WR-1 go to RST_OFF; otherwise increment the index and go to RD.
- RST_OFF: deassert o_mmcm_rst, clear the timeout counter, then go to LOCK_WAIT.
- LOCK_WAIT: o_locked=1 pulses o_done and returns to IDLE. If the counter reaches LOCK_TIMEOUT, go to ERR.
- RD_WAIT/WR_WAIT timeout: a 0-based counter reaching DRDY_TIMEOUT-1 without i_drdy goes to ERR.
- ERR: set o_err, deassert o_mmcm_rst (so the MMCM retries with whatever it holds), and go to IDLE the next cycle.
- An i_drdy arriving outside a WAIT state is ignored.
- Counters are wide enough for their timeout parameter (clog2).

## Timing
- Reset values: o_busy=0, o_done=0, o_err=0, o_den=0, o_dwe=0, o_daddr=0, o_di=0, o_mmcm_rst=0, o_locked=0, state IDLE.
- i_rst mid-sequence immediately returns to IDLE with o_mmcm_rst=0 and o_den=0.
- All outputs are registered.
- o_busy rises the cycle after i_req.
- o_mmcm_rst rises the cycle after i_req and falls on RST_OFF.
- The first o_den is 2 cycles after i_req.
- o_den is never high on two consecutive cycles.
- o_dwe and o_di are only meaningful while o_den=1.
- o_locked lags i_locked by 2 cycles.
- A lock already present when entering LOCK_WAIT is valid, because o_locked drops while the MMCM is in reset.
- Minimum request-to-done time with zero-latency DRDY is 2 + N_WR*4 + 1 + sync delay cycles.
- o_done and a new i_req in the same cycle: o_done has priority and the request is ignored.

## Test plan
- Single config, N_WR=2, DRP model with 3-cycle DRDY, stored value 0xFFFF, mask 0xF000, data 0x0123 -> write o_di=0xF123 at each address, o_mmcm_rst held through both writes, o_done 1 cycle after o_locked rises.
- i_cfg_sel=5 with N_CFG=2 -> o_err=1, no o_den, o_busy stays 0.
- DRP model never asserts DRDY -> ERR after DRDY_TIMEOUT cycles, o_err=1, o_mmcm_rst=0, o_busy=0.
- Lock never returns with LOCK_TIMEOUT=100 -> o_err at cycle 100 of LOCK_WAIT; the next valid request clears o_err and completes.
- i_rst asserted during WR_WAIT -> next cycle all outputs at reset values; a subsequent request runs from entry 0.
- i_req pulsed while busy -> ignored; exactly N_WR reads and N_WR writes observed, one o_done.
